// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add fixed-point multiplier.
// Holds the control FSM state encoding and the saturation limit helpers.
// Limits are computed at a fixed maximum width and sliced down by each user.
package mult_pkg;

    // Control FSM: wait for a start, iterate over the multiplier bits, emit result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest result magnitude the limit helpers can describe (must be >= 2*WIDTH).
    localparam int unsigned SAT_MAX_W = 256;

    // Largest positive value of a WIDTH-bit two's-complement number: 2^(width-1)-1.
    function automatic logic [SAT_MAX_W-1:0] sat_pos_limit(input int unsigned width);
        return (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
    endfunction

    // Magnitude of the most negative WIDTH-bit two's-complement number: 2^(width-1).
    function automatic logic [SAT_MAX_W-1:0] sat_neg_limit_mag(input int unsigned width);
        return SAT_MAX_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/sat_negate.sv
// Converts an unsigned product magnitude plus sign into a saturated signed result.
// Purely combinational (zero latency); no handshake, output follows inputs.
// A zero magnitude always yields zero, so a negative sign never produces -0 artefacts.
module sat_negate
    import mult_pkg::*;
#(
    parameter int WIDTH = 48
) (
    input  logic [2*WIDTH-1:0] i_mag,
    input  logic               i_sign,
    output logic [WIDTH-1:0]   o_z,
    output logic               o_ovf
);

    localparam logic [SAT_MAX_W-1:0] POS_LIM_FULL = sat_pos_limit(WIDTH);
    localparam logic [SAT_MAX_W-1:0] NEG_MAG_FULL = sat_neg_limit_mag(WIDTH);

    // Limits at the width of the incoming magnitude so comparisons are exact.
    localparam logic [2*WIDTH-1:0] POS_LIM = POS_LIM_FULL[2*WIDTH-1:0];
    localparam logic [2*WIDTH-1:0] NEG_MAG = NEG_MAG_FULL[2*WIDTH-1:0];

    // Clamp to the representable range for the sign, else pass or negate the magnitude.
    always_comb begin
        o_z   = '0;
        o_ovf = 1'b0;
        if (i_mag == '0) begin
            o_z   = '0;
            o_ovf = 1'b0;
        end else if (!i_sign) begin
            if (i_mag > POS_LIM) begin
                o_z   = POS_LIM[WIDTH-1:0];
                o_ovf = 1'b1;
            end else begin
                o_z   = i_mag[WIDTH-1:0];
            end
        end else begin
            if (i_mag > NEG_MAG) begin
                o_z   = NEG_MAG[WIDTH-1:0];
                o_ovf = 1'b1;
            end else begin
                // Magnitude 2^(WIDTH-1) negates to itself, which is exactly -2^(WIDTH-1).
                o_z   = (~i_mag[WIDTH-1:0]) + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential signed fixed-point multiplier: one shift-add iteration per clock on magnitudes.
// Latency WIDTH+1 clocks from accept to o_valid; one result per WIDTH+2 clocks back-to-back.
// No queuing: i_en is only honoured while o_ready=1, requests during a run are dropped.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int FRAC  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_z,
    output logic             o_ovf,
    output logic             o_valid
);

    // Counter must hold the value WIDTH itself.
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q,  state_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               sign_q,   sign_d;
    logic [WIDTH-1:0]   z_q,      z_d;
    logic               ovf_q,    ovf_d;
    logic               valid_q,  valid_d;

    logic [WIDTH-1:0]   x_abs;
    logic [WIDTH-1:0]   y_abs;
    logic [2*WIDTH-1:0] sat_mag;
    logic [WIDTH-1:0]   sat_z;
    logic               sat_ovf;

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
    always_comb begin
        x_abs = i_x[WIDTH-1] ? ((~i_x) + WIDTH'(1)) : i_x;
        y_abs = i_y[WIDTH-1] ? ((~i_y) + WIDTH'(1)) : i_y;
    end

    // Drop the fractional bits of the full product (truncates the magnitude toward zero).
    assign sat_mag = acc_q >> FRAC;

    sat_negate #(
        .WIDTH (WIDTH)
    ) u_sat_negate (
        .i_mag  (sat_mag),
        .i_sign (sign_q),
        .o_z    (sat_z),
        .o_ovf  (sat_ovf)
    );

    // Next-state and datapath: load on accept, one shift-add step per RUN cycle, publish in DONE.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        z_d      = z_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_en) begin
                    mcand_d  = {{WIDTH{1'b0}}, x_abs};
                    mplier_d = y_abs;
                    sign_d   = i_x[WIDTH-1] ^ i_y[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                cnt_d    = cnt_q - CNT_W'(1);
                // This edge performs the last iteration.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                z_d     = sat_z;
                ovf_d   = sat_ovf;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset wins over any start request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            z_q      <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            z_q      <= z_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    // Ready only while idle; the DONE->IDLE edge makes it coincide with the o_valid strobe.
    assign o_ready = (state_q == IDLE);
    assign o_z     = z_q;
    assign o_ovf   = ovf_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at WIDTH=48, FRAC=16.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed Q32.16 products.
module tb_shift_add_multiplier;

    localparam int WIDTH = 48;
    localparam int FRAC  = 16;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_en;
    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_y;
    logic             o_ready;
    logic [WIDTH-1:0] o_z;
    logic             o_ovf;
    logic             o_valid;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    shift_add_multiplier #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_x     (i_x),
        .i_y     (i_y),
        .o_ready (o_ready),
        .o_z     (o_z),
        .o_ovf   (o_ovf),
        .o_valid (o_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Count edges until o_valid rises; 0 means it never rose within the budget.
    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) begin
                n = k;
                break;
            end
        end
    endtask

    // Present a start request for exactly one edge.
    task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        i_en = 1'b1;
        i_x  = x;
        i_y  = y;
        @(posedge i_clk);
        #1;
        i_en = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic [WIDTH-1:0] exp_z, input logic exp_ovf);
        int n;
        accept(x, y);
        chk({tag, "_busy"}, 64'(o_ready), 64'(0));
        wait_valid(n);
        chk({tag, "_lat"}, 64'(n), 64'(49));
        chk({tag, "_z"}, 64'(o_z), 64'(exp_z));
        chk({tag, "_ovf"}, 64'(o_ovf), 64'(exp_ovf));
        chk({tag, "_rdy"}, 64'(o_ready), 64'(1));
        @(posedge i_clk);
        #1;
        chk({tag, "_pulse"}, 64'(o_valid), 64'(0));
    endtask

    initial begin
        int n;
        int seen;
        i_rst = 1'b1;
        i_en  = 1'b0;
        i_x   = '0;
        i_y   = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", 64'(o_ready), 64'(1));
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_z", 64'(o_z), 64'(0));
        chk("rst_ovf", 64'(o_ovf), 64'(0));
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // 3.0 * 2.0 = 6.0
        run_op("pos", 48'h0000_0003_0000, 48'h0000_0002_0000, 48'h0000_0006_0000, 1'b0);
        // -1.5 * 2.0 = -3.0
        run_op("neg", 48'hFFFF_FFFE_8000, 48'h0000_0002_0000, 48'hFFFF_FFFD_0000, 1'b0);
        // 2^40 * 2^40 saturates positive
        run_op("satp", 48'h0100_0000_0000, 48'h0100_0000_0000, 48'h7FFF_FFFF_FFFF, 1'b1);
        // -2^40 * 2^40 saturates negative
        run_op("satn", 48'hFF00_0000_0000, 48'h0100_0000_0000, 48'h8000_0000_0000, 1'b1);
        // -2^47 * 1.0 is exactly representable
        run_op("minv", 48'h8000_0000_0000, 48'h0000_0001_0000, 48'h8000_0000_0000, 1'b0);

        // Result holds while idle
        repeat (3) @(posedge i_clk);
        #1;
        chk("hold_z", 64'(o_z), 64'(48'h8000_0000_0000));
        chk("hold_valid", 64'(o_valid), 64'(0));

        // 0 * -1.0 gives zero regardless of sign
        run_op("zero", 48'h0000_0000_0000, 48'hFFFF_FFFF_0000, 48'h0000_0000_0000, 1'b0);

        // Start request at clock 10 of a run is dropped
        accept(48'h0000_0003_0000, 48'h0000_0002_0000);
        repeat (9) @(posedge i_clk);
        #1;
        i_en = 1'b1;
        i_x  = 48'h0000_0005_0000;
        i_y  = 48'h0000_0005_0000;
        @(posedge i_clk);
        #1;
        i_en = 1'b0;
        wait_valid(n);
        chk("ign_lat", 64'(n), 64'(39));
        chk("ign_z", 64'(o_z), 64'(48'h0000_0006_0000));
        chk("ign_ovf", 64'(o_ovf), 64'(0));

        // Start in the o_valid cycle is accepted: 1.0 * -2.0 = -2.0
        accept(48'h0000_0001_0000, 48'hFFFF_FFFE_0000);
        chk("b2b_busy", 64'(o_ready), 64'(0));
        wait_valid(n);
        chk("b2b_lat", 64'(n), 64'(49));
        chk("b2b_z", 64'(o_z), 64'(48'hFFFF_FFFE_0000));

        // Reset at clock 20 of a run aborts it; i_en during reset is ignored
        accept(48'h0000_0003_0000, 48'h0000_0002_0000);
        repeat (19) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        i_en  = 1'b1;
        i_x   = 48'h0000_0007_0000;
        i_y   = 48'h0000_0001_0000;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_en  = 1'b0;
        chk("abort_ready", 64'(o_ready), 64'(1));
        chk("abort_valid", 64'(o_valid), 64'(0));
        chk("abort_z", 64'(o_z), 64'(0));
        seen = 0;
        repeat (60) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'(0));
        chk("abort_idle", 64'(o_ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 48, the operand and result width in bits.
REQ-002 The block SHALL have parameter FRAC, default 16, the number of fractional bits in the fixed-point operands and result; 0 <= FRAC < WIDTH.
REQ-003 The block SHALL have port i_clk  input  1  clock, rising-edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port i_en  input  1  start request, sampled only while o_ready=1.
REQ-006 The block SHALL have ports i_x and i_y  input  WIDTH  signed two's-complement operands, sampled on the accepting edge.
REQ-007 The block SHALL have port o_ready  output  1  idle, able to accept i_en.
REQ-008 The block SHALL have port o_z  output  WIDTH  signed result (x*y)>>FRAC, saturated.
REQ-009 The block SHALL have port o_ovf  output  1  saturation occurred, qualified by o_valid.
REQ-010 The block SHALL have port o_valid  output  1  single-cycle result strobe.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE; o_ready=1 only in IDLE.
REQ-012 IDLE with i_en=1 at edge 0: the block SHALL latch |i_x|, |i_y| as WIDTH-bit unsigned values, latch sign = i_x[MSB] XOR i_y[MSB], clear the 2*WIDTH-bit accumulator, load iteration count WIDTH and go to RUN.
REQ-013 RUN, each edge: if multiplier LSB=1, the block SHALL add the multiplicand (shifted) to the accumulator; it SHALL then shift the multiplier right by 1 and the multiplicand left by 1, and decrement the count. After WIDTH iterations (edges 1..WIDTH) it SHALL go to DONE.
REQ-014 DONE, edge WIDTH+1: the block SHALL compute R = accumulator >> FRAC (truncation toward zero on magnitude), apply saturation, register o_z and o_ovf, pulse o_valid=1 for exactly one cycle and return to IDLE.
REQ-015 Saturation: positive sign with R > 2^(WIDTH-1)-1 SHALL give o_z = 2^(WIDTH-1)-1 and o_ovf=1; negative sign with R > 2^(WIDTH-1) SHALL give o_z = -2^(WIDTH-1) and o_ovf=1; otherwise o_z SHALL equal R, or its two's-complement negation for negative sign, with o_ovf=0.
REQ-016 A zero magnitude result SHALL yield o_z=0 regardless of sign.
REQ-017 An operand of -2^(WIDTH-1) SHALL be handled exactly (magnitude 2^(WIDTH-1) fits in unsigned WIDTH bits).
REQ-018 Latency SHALL be WIDTH+1 clocks from the accept edge to the edge that raises o_valid; o_ready SHALL be 1 in the same cycle as o_valid, so back-to-back starts give one result per WIDTH+2 clocks.
REQ-019 i_en while o_ready=0 SHALL be ignored; no queuing.
REQ-020 o_z and o_ovf SHALL hold their last values until the next DONE.

Reset
REQ-021 When i_rst=1 on an edge: state SHALL become IDLE; o_z, o_ovf and o_valid SHALL become 0; o_ready SHALL become 1; all internal registers SHALL be cleared.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no o_valid pulse; i_en in the reset cycle SHALL be ignored.

Structure
REQ-023 Package mult_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the saturation limit constants as WIDTH-parameterised functions.
REQ-024 Saturation/negation SHALL be a combinational sub-module sat_negate (inputs: magnitude, sign; outputs: z, ovf), instantiated once.

Verification (WIDTH=48, FRAC=16)
REQ-025 The bench SHALL cover: x=0x30000 (3.0), y=0x20000 (2.0) -> after 49 clocks o_valid=1, o_z=0x60000, o_ovf=0.
REQ-026 The bench SHALL cover: x=-0x18000 (-1.5), y=0x20000 -> o_z=-0x30000, o_ovf=0.
REQ-027 The bench SHALL cover: x=y=2^40 -> o_z=0x7FFF_FFFF_FFFF, o_ovf=1; x=-2^40, y=2^40 -> o_z=-2^47, o_ovf=1.
REQ-028 The bench SHALL cover: x=-2^47, y=0x10000 (1.0) -> o_z=-2^47, o_ovf=0.
REQ-029 The bench SHALL cover: start, then pulse i_en with new operands at clock 10 -> ignored, the first result is unchanged; a new i_en in the o_valid cycle is accepted.
REQ-030 The bench SHALL cover: i_rst at clock 20 of RUN -> o_ready=1 next cycle, no o_valid, o_z=0.
